// File: rtl/contador_regressivo.sv
`default_nettype none
// ============================================================================
//  Module      : contador_regressivo
//  Description : Loadable synchronous down-counter/timer with a registered
//                terminal-count pulse (fim) and an optional auto-reload mode.
//                Counts from a loaded value down to zero. In auto-reload mode
//                it restarts from the reload register one enabled cycle after
//                reaching zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_regressivo #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             carga,
   input  logic [WIDTH-1:0] valor,
   input  logic             habilita,
   input  logic             recarga,
   output logic [WIDTH-1:0] saida,
   output logic             zero,
   output logic             fim
);

   // FSM encoding: stopped / running
   localparam logic [0:0] c_ocioso   = 1'b0;
   localparam logic [0:0] c_contando = 1'b1;

   localparam logic [WIDTH-1:0] c_um   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_nulo = '0;

   logic [0:0]       r_estado;
   logic [WIDTH-1:0] r_saida;
   logic [WIDTH-1:0] r_recarga_val;
   logic             r_modo;
   logic             r_fim;

   logic [0:0]       w_estado_prox;
   logic [WIDTH-1:0] w_saida_prox;
   logic [WIDTH-1:0] w_recarga_val_prox;
   logic             w_modo_prox;
   logic             w_fim_prox;

   // State register: FSM state, count, reload value, mode bit and fim pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado      <= c_ocioso;
         r_saida       <= c_nulo;
         r_recarga_val <= c_nulo;
         r_modo        <= 1'b0;
         r_fim         <= 1'b0;
      end else begin
         r_estado      <= w_estado_prox;
         r_saida       <= w_saida_prox;
         r_recarga_val <= w_recarga_val_prox;
         r_modo        <= w_modo_prox;
         r_fim         <= w_fim_prox;
      end
   end

   // Next-state logic: load has top priority, then enabled counting
   always_comb begin
      w_estado_prox      = r_estado;
      w_saida_prox       = r_saida;
      w_recarga_val_prox = r_recarga_val;
      w_modo_prox        = r_modo;
      w_fim_prox         = 1'b0;

      if (carga) begin
         w_saida_prox       = valor;
         w_recarga_val_prox = valor;
         w_modo_prox        = recarga;
         w_estado_prox      = (valor != c_nulo) ? c_contando : c_ocioso;
      end else if ((r_estado == c_contando) && habilita) begin
         if (r_saida > c_um) begin
            w_saida_prox = r_saida - c_um;
         end else if (r_saida == c_um) begin
            // Terminal edge: fim is registered alongside the transition to 0
            w_saida_prox = c_nulo;
            w_fim_prox   = 1'b1;
            if (!r_modo) begin
               w_estado_prox = c_ocioso;
            end
         end else begin
            // Sitting at 0 while running only happens in auto-reload mode
            w_saida_prox = r_recarga_val;
         end
      end
   end

   // Output decode: registered count and pulse, combinational zero flag
   always_comb begin
      saida = r_saida;
      fim   = r_fim;
      zero  = (r_saida == c_nulo);
   end

endmodule
`default_nettype wire

// File: tb/tb_contador_regressivo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_regressivo
//  Description : Self-checking bench for contador_regressivo: directed vector
//                table, hand-written reset sequences and a randomized phase
//                compared against a behavioural timer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_regressivo;

   localparam int WIDTH = 4;

   logic             clock;
   logic             reset_n;
   logic             carga;
   logic [WIDTH-1:0] valor;
   logic             habilita;
   logic             recarga;
   logic [WIDTH-1:0] saida;
   logic             zero;
   logic             fim;

   int n_total = 0;
   int n_pass  = 0;

   contador_regressivo #(.WIDTH(WIDTH)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .carga    (carga),
      .valor    (valor),
      .habilita (habilita),
      .recarga  (recarga),
      .saida    (saida),
      .zero     (zero),
      .fim      (fim)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       c;
      logic [3:0] v;
      logic       h;
      logic       r;
      logic [3:0] exp_saida;
      logic       exp_fim;
   } vec_t;

   vec_t vecs[$];

   // Behavioural model: a timer described by its count, reload, mode, running
   int  m_cnt, m_reload;
   bit  m_auto, m_run, m_fim;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   task automatic add(input logic c, input int v, input logic h, input logic r,
                      input int es, input logic ef);
      vec_t x;
      x.c = c; x.v = v[3:0]; x.h = h; x.r = r;
      x.exp_saida = es[3:0]; x.exp_fim = ef;
      vecs.push_back(x);
   endtask

   // One clock: drive inputs, clock edge, sample 1 ns later
   task automatic step(input logic c, input logic [3:0] v, input logic h, input logic r);
      carga = c; valor = v; habilita = h; recarga = r;
      @(posedge clock);
      #1;
   endtask

   function automatic void model_reset();
      m_cnt = 0; m_reload = 0; m_auto = 0; m_run = 0; m_fim = 0;
   endfunction

   function automatic void model_step(input bit c, input int v, input bit h, input bit r);
      m_fim = 0;
      if (c) begin
         m_cnt = v; m_reload = v; m_auto = r; m_run = (v != 0);
      end else if (m_run && h) begin
         if (m_cnt == 0) m_cnt = m_reload;
         else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_fim = 1;
               if (!m_auto) m_run = 0;
            end
         end
      end
   endfunction

   initial begin
      carga = 0; valor = 0; habilita = 0; recarga = 0;
      reset_n = 1'b0;
      #3;
      check("reset_saida", saida, 0);
      check("reset_zero",  zero,  1);
      check("reset_fim",   fim,   0);
      #9 reset_n = 1'b1;

      // idle with habilita high
      for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0);
      // one-shot from 3
      add(1, 3, 0, 0, 3, 0);
      add(0, 0, 1, 0, 2, 0);
      add(0, 0, 1, 0, 1, 0);
      add(0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0);
      // auto-reload from 2 (habilita ignored on the load cycle)
      add(1, 2, 1, 1, 2, 0);
      add(0, 0, 1, 0, 1, 0);
      add(0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 0, 2, 0);
      add(0, 0, 1, 0, 1, 0);
      add(0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 0, 2, 0);
      // pause then reload while running
      add(1, 5, 0, 0, 5, 0);
      add(0, 0, 1, 0, 4, 0);
      add(0, 0, 0, 0, 4, 0);
      add(0, 0, 0, 0, 4, 0);
      add(0, 0, 1, 0, 3, 0);
      add(1, 9, 1, 0, 9, 0);
      // load wins over terminal count
      add(1, 1, 0, 0, 1, 0);
      add(1, 7, 1, 0, 7, 0);
      // load zero stays idle
      add(1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0);
      // max load value
      add(1, 15, 0, 0, 15, 0);
      add(0, 0, 1, 0, 14, 0);
      add(0, 0, 1, 0, 13, 0);

      foreach (vecs[i]) begin
         step(vecs[i].c, vecs[i].v, vecs[i].h, vecs[i].r);
         check($sformatf("vec%0d_saida", i), saida, vecs[i].exp_saida);
         check($sformatf("vec%0d_zero", i),  zero,  (vecs[i].exp_saida == 0) ? 1 : 0);
         check($sformatf("vec%0d_fim", i),   fim,   vecs[i].exp_fim);
      end

      // asynchronous reset mid-count, observed before the next edge
      carga = 0; habilita = 1;
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_saida", saida, 0);
      check("async_rst_zero",  zero,  1);
      check("async_rst_fim",   fim,   0);
      @(posedge clock); #1;
      check("rst_hold_saida", saida, 0);
      #3 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 4'd0, 1, 0);
         check("post_rst_idle_saida", saida, 0);
         check("post_rst_idle_fim",   fim,   0);
      end
      step(1, 4'd4, 0, 0);
      check("post_rst_load", saida, 4);

      // reset on the terminal edge produces no pulse
      step(1, 4'd1, 0, 1);
      habilita = 1;
      #2 reset_n = 1'b0;
      @(posedge clock); #1;
      check("rst_at_term_fim",   fim,   0);
      check("rst_at_term_saida", saida, 0);
      #2 reset_n = 1'b1;

      // randomized phase against the model
      step(0, 4'd0, 0, 0);
      model_reset();
      for (int i = 0; i < 600; i++) begin
         logic       c, h, r;
         logic [3:0] v;
         c = ($urandom_range(0, 9) == 0);
         v = 4'($urandom_range(0, 15));
         h = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 1) == 1;
         step(c, v, h, r);
         model_step(c, v, h, r);
         check("rnd_saida", saida, m_cnt);
         check("rnd_zero",  zero,  (m_cnt == 0) ? 1 : 0);
         check("rnd_fim",   fim,   m_fim);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/contador_regressivo.md
Name: contador_regressivo

Overview:
- Synchronous, loadable down-counter/timer. It is the counterpart of the team's ripple up-counter: it counts down from a loaded value to zero instead of up from zero.
- Used as a countdown/delay timer by the processor control logic, e.g. for wait states and multi-cycle operation timeouts.
- Fully synchronous to one clock, with a registered terminal-count pulse and an optional auto-reload mode.

Parameters:
- WIDTH, 4, bit width of the count and of the load value.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- carga  input  1  load strobe; samples valor on this edge.
- valor  input  WIDTH  value to load.
- habilita  input  1  count enable; one decrement per enabled cycle.
- recarga  input  1  auto-reload mode select; sampled together with carga.
- saida  output  WIDTH  current count (registered).
- zero  output  1  high when saida == 0 (combinational decode of the saida register).
- fim  output  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset, asynchronous on reset_n low, effective immediately:
  - saida = 0, fim = 0, zero = 1.
  - Internal reload register = 0, internal mode bit = 0.
  - FSM goes to OCIOSO.
  - Reset asserted mid-count aborts the count with no fim pulse.
- FSM states: OCIOSO (stopped) and CONTANDO (running).
- Load, carga = 1, any state, highest priority:
  - saida <= valor; reload register <= valor; mode bit <= recarga; fim <= 0.
  - Next state is CONTANDO if valor != 0, otherwise OCIOSO.
  - habilita is ignored on a load cycle.
- OCIOSO:
  - saida holds; habilita is ignored; fim <= 0.
  - Only carga leaves this state.
- CONTANDO, habilita = 0:
  - saida holds; fim <= 0; state holds. This is a pause, not an abort.
- CONTANDO, habilita = 1, saida > 1:
  - saida <= saida - 1; fim <= 0.
- CONTANDO, habilita = 1, saida == 1:
  - saida <= 0; fim <= 1 on that same edge.
  - fim is high for exactly the one cycle in which saida first reads 0.
  - Mode bit 0: next state OCIOSO; saida then holds at 0.
  - Mode bit 1: state stays CONTANDO.
- CONTANDO, habilita = 1, saida == 0 (only reachable in auto-reload mode):
  - saida <= reload register; fim <= 0.
  - Auto-reload period is therefore N+1 enabled cycles for a load value N.
- Arithmetic:
  - Decrement is modulo 2^WIDTH, but no underflow can occur: saida never decrements from 0.
  - Maximum load value is 2^WIDTH - 1.
- Latency: saida changes on the first rising edge after carga or habilita is sampled high. There is no combinational path from any input to saida or fim.
- Load on the same cycle as terminal count: the load wins, fim stays 0, and the new value is visible next cycle.
- Load while running: restarts immediately with the new value and mode.
- zero and fim differ:
  - zero is a level that stays high while stopped at 0.
  - fim is a single pulse that is never re-asserted while idle.

Test Plan:
- Reset release, then idle 5 cycles -> saida = 0, zero = 1, fim = 0 throughout; habilita = 1 has no effect.
- carga with valor = 3, recarga = 0, then habilita held 1 -> saida reads 3, 2, 1, 0; fim high only in the cycle saida first reads 0; saida stays 0 and fim stays 0 afterwards.
- carga with valor = 2, recarga = 1, habilita held 1 -> saida reads 2, 1, 0, 2, 1, 0, 2…; fim pulses once every 3 cycles, coinciding with each 0.
- valor = 5 loaded; habilita toggles 1,0,0,1 -> saida reads 4, 4, 4, 3 (pause holds the count); then carga with valor = 9 while saida = 3 -> saida = 9 next cycle with no fim pulse.
- Load valor = 1 and count to the terminal edge, but assert carga with valor = 7 on that edge -> saida = 7, fim = 0. Separately, load valor = 0 -> state OCIOSO, zero = 1, no fim.
- Load valor = 15 (WIDTH = 4), then pull reset_n low mid-count between clock edges -> saida = 0 and zero = 1 immediately, before the next edge; fim = 0; after release, habilita has no effect until the next carga.
